gate_bank_core: RTL and testbench

GATE_BANK_CORE -- requirements
Module: gate_bank_core

---
 rtl/gate_bank_if.sv | 25 ++
 rtl/gate_bank_core.sv | 124 ++++++++++++
 tb/tb_gate_bank_core.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/gate_bank_if.sv
// Pin bundle for gate_bank_core: switch operands and pushbuttons in, LED/mode/display out.
// slave is the core's view, master is the board/driver side.
interface gate_bank_if #(
   parameter int CH = 4
);
   logic [CH-1:0] a;
   logic [CH-1:0] b;
   logic          key_next_n;
   logic          key_prev_n;
   logic          key_hold_n;
   logic [CH-1:0] y;
   logic [2:0]    mode;
   logic          held;
   logic [6:0]    hex;

   modport slave (
      input  a, b, key_next_n, key_prev_n, key_hold_n,
      output y, mode, held, hex
   );

   modport master (
      output a, b, key_next_n, key_prev_n, key_hold_n,
      input  y, mode, held, hex
   );
endinterface

// File: rtl/gate_bank_core.sv
// Bitwise gate bank: synchronized switch operands, pushbutton mode select and output freeze.
// Define GATE_BANK_HEX_EN to compile the seven-segment mode decoder; otherwise hex is blank.
module gate_bank_core #(
   parameter int CH          = 4,
   parameter int SYNC_STAGES = 2
) (
   input logic        clk,
   input logic        reset_n,
   gate_bank_if.slave bus
);
   typedef enum logic [2:0] {
      M_BUF, M_INV, M_AND, M_OR, M_NAND, M_NOR, M_XOR, M_XNOR
   } gate_mode_t;

   logic [CH-1:0]        r_a_sync   [SYNC_STAGES];
   logic [CH-1:0]        r_b_sync   [SYNC_STAGES];
   logic [2:0]           r_key_sync [SYNC_STAGES];
   logic [2:0]           r_key_prev;
   logic [SYNC_STAGES:0] r_arm;
   gate_mode_t           r_mode;
   logic                 r_held;
   logic [CH-1:0]        r_y;

   gate_mode_t    w_mode_nxt;
   logic [2:0]    w_key_pin;
   logic [2:0]    w_key_s;
   logic [2:0]    w_press;
   logic [CH-1:0] w_a_s;
   logic [CH-1:0] w_b_s;

   function automatic logic [CH-1:0] f_gate(input gate_mode_t m,
                                            input logic [CH-1:0] a,
                                            input logic [CH-1:0] b);
      case (m)
         M_BUF:   f_gate = a;
         M_INV:   f_gate = ~a;
         M_AND:   f_gate = a & b;
         M_OR:    f_gate = a | b;
         M_NAND:  f_gate = ~(a & b);
         M_NOR:   f_gate = ~(a | b);
         M_XOR:   f_gate = a ^ b;
         default: f_gate = ~(a ^ b);
      endcase
   endfunction

   // Key bit order: [0] next, [1] prev, [2] hold.
   assign w_key_pin = {bus.key_hold_n, bus.key_prev_n, bus.key_next_n};
   assign w_key_s   = r_key_sync[SYNC_STAGES-1];
   assign w_a_s     = r_a_sync[SYNC_STAGES-1];
   assign w_b_s     = r_b_sync[SYNC_STAGES-1];

   // r_arm marks when both the sync output and the edge flop hold real pin samples, so a
   // key already down at reset release is seen as low/low and never as a falling edge.
   assign w_press = {3{r_arm[SYNC_STAGES]}} & r_key_prev & ~w_key_s;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            r_a_sync[i]   <= '0;
            r_b_sync[i]   <= '0;
            r_key_sync[i] <= '1;
         end
         r_key_prev <= '1;
         r_arm      <= '0;
      end else begin
         r_a_sync[0]   <= bus.a;
         r_b_sync[0]   <= bus.b;
         r_key_sync[0] <= w_key_pin;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_a_sync[i]   <= r_a_sync[i-1];
            r_b_sync[i]   <= r_b_sync[i-1];
            r_key_sync[i] <= r_key_sync[i-1];
         end
         r_key_prev <= w_key_s;
         r_arm      <= {r_arm[SYNC_STAGES-1:0], 1'b1};
      end
   end

   always_comb begin
      w_mode_nxt = r_mode;
      case ({w_press[0], w_press[1]})
         2'b10:   w_mode_nxt = gate_mode_t'(r_mode + 3'd1);
         2'b01:   w_mode_nxt = gate_mode_t'(r_mode - 3'd1);
         default: w_mode_nxt = r_mode;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mode <= M_BUF;
         r_held <= 1'b0;
         r_y    <= '0;
      end else begin
         r_mode <= w_mode_nxt;
         r_held <= r_held ^ w_press[2];
         if (!r_held) begin
            r_y <= f_gate(r_mode, w_a_s, w_b_s);
         end
      end
   end

   assign bus.y    = r_y;
   assign bus.mode = r_mode;
   assign bus.held = r_held;

`ifdef GATE_BANK_HEX_EN
   function automatic logic [6:0] f_hex(input gate_mode_t m);
      case (m)
         M_BUF:   f_hex = 7'b1000000;
         M_INV:   f_hex = 7'b1111001;
         M_AND:   f_hex = 7'b0100100;
         M_OR:    f_hex = 7'b0110000;
         M_NAND:  f_hex = 7'b0011001;
         M_NOR:   f_hex = 7'b0010010;
         M_XOR:   f_hex = 7'b0000010;
         default: f_hex = 7'b1111000;
      endcase
   endfunction

   assign bus.hex = f_hex(r_mode);
`else
   assign bus.hex = 7'b1111111;
`endif
endmodule

// File: tb/tb_gate_bank_core.sv
// Self-checking bench for gate_bank_core: directed pin-level scenarios plus random key/switch
// activity compared against a truth-table model of the gate bank.
module tb_gate_bank_core;
   localparam int CH = 4;
   localparam int S  = 2;

   logic clk = 1'b0;
   logic reset_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   int         m_mode;
   bit         m_held;
   logic [3:0] m_y;
   logic [3:0] m_a;
   logic [3:0] m_b;

   gate_bank_if #(.CH(CH)) bus ();

   gate_bank_core #(.CH(CH), .SYNC_STAGES(S)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Per-mode truth table indexed by {a_bit, b_bit}.
   function automatic logic [3:0] ref_tt(input int m);
      case (m)
         0: return 4'b1100;
         1: return 4'b0011;
         2: return 4'b1000;
         3: return 4'b1110;
         4: return 4'b0111;
         5: return 4'b0001;
         6: return 4'b0110;
         default: return 4'b1001;
      endcase
   endfunction

   function automatic logic [3:0] ref_gate(input int m, input logic [3:0] a, input logic [3:0] b);
      logic [3:0] tt;
      logic [3:0] r;
      tt = ref_tt(m);
      for (int i = 0; i < 4; i++) r[i] = tt[{a[i], b[i]}];
      return r;
   endfunction

   function automatic logic [6:0] ref_hex(input int m);
`ifdef GATE_BANK_HEX_EN
      case (m)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         default: return 7'b1111000;
      endcase
`else
      return 7'b1111111 | 7'(m & 0);
`endif
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_ab(input logic [3:0] a, input logic [3:0] b);
      bus.a = a;
      bus.b = b;
      m_a = a;
      m_b = b;
      step(S + 3);
      if (!m_held) m_y = ref_gate(m_mode, m_a, m_b);
   endtask

   task automatic keys(input bit nx, input bit pv, input bit hd, input int len);
      bus.key_next_n = !nx;
      bus.key_prev_n = !pv;
      bus.key_hold_n = !hd;
      step(len);
      bus.key_next_n = 1'b1;
      bus.key_prev_n = 1'b1;
      bus.key_hold_n = 1'b1;
      step(S + 3);
      m_mode = (m_mode + int'(nx) - int'(pv) + 8) % 8;
      if (hd) m_held = !m_held;
      if (!m_held) m_y = ref_gate(m_mode, m_a, m_b);
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.key_next_n = 1'b1;
      bus.key_prev_n = 1'b1;
      bus.key_hold_n = 1'b1;
      m_mode = 0; m_held = 0; m_y = '0; m_a = '0; m_b = '0;
      step(3);
      n_tests++; if (bus.y !== 4'b0000) begin n_fail++; $display("FAIL reset_y: got %b want 0000", bus.y); end
      n_tests++; if (bus.mode !== 3'd0) begin n_fail++; $display("FAIL reset_mode: got %0d want 0", bus.mode); end
      n_tests++; if (bus.held !== 1'b0) begin n_fail++; $display("FAIL reset_held: got %b want 0", bus.held); end
      n_tests++; if (bus.hex !== ref_hex(0)) begin n_fail++; $display("FAIL reset_hex: got %b want %b", bus.hex, ref_hex(0)); end
      reset_n = 1'b1;
      step(S + 3);
   endtask

   task automatic test_latency;
      bus.a = 4'b1010;
      bus.b = 4'b0110;
      m_a = 4'b1010; m_b = 4'b0110;
      step(S);
      n_tests++; if (bus.y !== 4'b0000) begin n_fail++; $display("FAIL latency_early: got %b want 0000", bus.y); end
      step(1);
      n_tests++; if (bus.y !== 4'b1010) begin n_fail++; $display("FAIL latency_buf: got %b want 1010", bus.y); end
      n_tests++; if (bus.hex !== ref_hex(0)) begin n_fail++; $display("FAIL latency_hex: got %b want %b", bus.hex, ref_hex(0)); end
      m_y = 4'b1010;
      step(2);
   endtask

   task automatic test_next_wrap;
      for (int i = 0; i < 6; i++) keys(1, 0, 0, 3);
      n_tests++; if (bus.mode !== 3'd6) begin n_fail++; $display("FAIL next6_mode: got %0d want 6", bus.mode); end
      n_tests++; if (bus.y !== 4'b1100) begin n_fail++; $display("FAIL next6_xor: got %b want 1100", bus.y); end
      n_tests++; if (bus.hex !== ref_hex(6)) begin n_fail++; $display("FAIL next6_hex: got %b want %b", bus.hex, ref_hex(6)); end
      keys(1, 0, 0, 2);
      n_tests++; if (bus.mode !== 3'd7) begin n_fail++; $display("FAIL next7_mode: got %0d want 7", bus.mode); end
      keys(1, 0, 0, 2);
      n_tests++; if (bus.mode !== 3'd0) begin n_fail++; $display("FAIL wrap_mode: got %0d want 0", bus.mode); end
      n_tests++; if (bus.y !== 4'b1010) begin n_fail++; $display("FAIL wrap_y: got %b want 1010", bus.y); end
   endtask

   task automatic test_prev_both;
      keys(0, 1, 0, 2);
      n_tests++; if (bus.mode !== 3'd7) begin n_fail++; $display("FAIL prev_wrap_mode: got %0d want 7", bus.mode); end
      n_tests++; if (bus.y !== 4'b0011) begin n_fail++; $display("FAIL prev_xnor: got %b want 0011", bus.y); end
      keys(1, 1, 0, 2);
      n_tests++; if (bus.mode !== 3'd7) begin n_fail++; $display("FAIL both_mode: got %0d want 7", bus.mode); end
   endtask

   task automatic test_hold;
      for (int i = 0; i < 3; i++) keys(1, 0, 0, 2);
      n_tests++; if (bus.y !== 4'b0010) begin n_fail++; $display("FAIL hold_and_y: got %b want 0010", bus.y); end
      keys(0, 0, 1, 2);
      n_tests++; if (bus.held !== 1'b1) begin n_fail++; $display("FAIL hold_set: got %b want 1", bus.held); end
      set_ab(4'b1111, 4'b1111);
      keys(1, 0, 0, 2);
      keys(1, 0, 0, 2);
      n_tests++; if (bus.y !== 4'b0010) begin n_fail++; $display("FAIL hold_frozen_y: got %b want 0010", bus.y); end
      n_tests++; if (bus.mode !== 3'd4) begin n_fail++; $display("FAIL hold_mode: got %0d want 4", bus.mode); end
      n_tests++; if (bus.hex !== ref_hex(4)) begin n_fail++; $display("FAIL hold_hex: got %b want %b", bus.hex, ref_hex(4)); end
      keys(0, 0, 1, 2);
      n_tests++; if (bus.held !== 1'b0) begin n_fail++; $display("FAIL unhold: got %b want 0", bus.held); end
      n_tests++; if (bus.y !== 4'b0000) begin n_fail++; $display("FAIL unhold_nand: got %b want 0000", bus.y); end
   endtask

   task automatic test_long_press_reset;
      bus.key_next_n = 1'b0;
      step(1000);
      n_tests++; if (bus.mode !== 3'd5) begin n_fail++; $display("FAIL long_press_mode: got %0d want 5", bus.mode); end
      bus.key_next_n = 1'b1;
      step(S + 3);
      n_tests++; if (bus.mode !== 3'd5) begin n_fail++; $display("FAIL long_release_mode: got %0d want 5", bus.mode); end
      m_mode = 5;
      set_ab(4'b0000, 4'b0000);
      n_tests++; if (bus.y !== 4'b1111) begin n_fail++; $display("FAIL nor_y: got %b want 1111", bus.y); end
      keys(0, 0, 1, 2);
      bus.key_next_n = 1'b0;
      step(1);
      #2 reset_n = 1'b0;
      #1;
      n_tests++; if (bus.mode !== 3'd0) begin n_fail++; $display("FAIL async_rst_mode: got %0d want 0", bus.mode); end
      n_tests++; if (bus.y !== 4'b0000) begin n_fail++; $display("FAIL async_rst_y: got %b want 0000", bus.y); end
      n_tests++; if (bus.held !== 1'b0) begin n_fail++; $display("FAIL async_rst_held: got %b want 0", bus.held); end
      step(3);
      reset_n = 1'b1;
      m_mode = 0; m_held = 0;
      step(20);
      n_tests++; if (bus.mode !== 3'd0) begin n_fail++; $display("FAIL rst_release_press: got %0d want 0", bus.mode); end
      bus.key_next_n = 1'b1;
      step(S + 3);
      n_tests++; if (bus.mode !== 3'd0) begin n_fail++; $display("FAIL rst_key_release: got %0d want 0", bus.mode); end
      m_y = ref_gate(m_mode, m_a, m_b);
   endtask

   task automatic test_hex_mode5;
      for (int i = 0; i < 5; i++) keys(1, 0, 0, 2);
      n_tests++; if (bus.hex !== ref_hex(5)) begin n_fail++; $display("FAIL hex_mode5: got %b want %b", bus.hex, ref_hex(5)); end
      n_tests++; if (bus.mode !== 3'd5) begin n_fail++; $display("FAIL hex_mode5_mode: got %0d want 5", bus.mode); end
   endtask

   task automatic test_random;
      int act;
      for (int it = 0; it < 80; it++) begin
         act = int'($urandom_range(0, 4));
         case (act)
            0: set_ab(4'($urandom), 4'($urandom));
            1: keys(1, 0, 0, int'($urandom_range(1, 6)));
            2: keys(0, 1, 0, int'($urandom_range(1, 6)));
            3: keys(1, 1, 0, int'($urandom_range(1, 6)));
            default: keys(0, 0, 1, int'($urandom_range(1, 6)));
         endcase
         n_tests++; if (bus.y !== m_y) begin n_fail++; $display("FAIL rand_y[%0d]: got %b want %b", it, bus.y, m_y); end
         n_tests++; if (bus.mode !== 3'(m_mode)) begin n_fail++; $display("FAIL rand_mode[%0d]: got %0d want %0d", it, bus.mode, m_mode); end
         n_tests++; if (bus.held !== m_held) begin n_fail++; $display("FAIL rand_held[%0d]: got %b want %b", it, bus.held, m_held); end
         n_tests++; if (bus.hex !== ref_hex(m_mode)) begin n_fail++; $display("FAIL rand_hex[%0d]: got %b want %b", it, bus.hex, ref_hex(m_mode)); end
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_next_wrap();
      test_prev_both();
      test_hold();
      test_long_press_reset();
      test_hex_mode5();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
